// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: redirect/control inputs and fetch address outputs.
// master = fetch/decode control that drives requests, slave = the PC generator.
interface pc_gen_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  stall;
  logic [1:0]            PCsrc;
  logic [DATA_WIDTH-1:0] ImmOp;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic                  trap_req;
  logic                  trap_ret;
  logic [DATA_WIDTH-1:0] pcounter;
  logic [DATA_WIDTH-1:0] pc_plus;
  logic                  pc_valid;
  logic                  misalign;
  logic [DATA_WIDTH-1:0] fault_addr;
  logic [DATA_WIDTH-1:0] epc;

  modport master (
    output stall, PCsrc, ImmOp, rs1_val, trap_req, trap_ret,
    input  pcounter, pc_plus, pc_valid, misalign, fault_addr, epc
  );

  modport slave (
    input  stall, PCsrc, ImmOp, rs1_val, trap_req, trap_ret,
    output pcounter, pc_plus, pc_valid, misalign, fault_addr, epc
  );
endinterface

// File: rtl/pc_gen.sv
// RV32 fetch program-counter generator: sequential, branch/JAL, JALR, trap and trap-return paths,
// with stall hold, boot/fault bubbles, misaligned-target trap redirect and an internal EPC.
//
// state   | meaning
// S_BOOT  | one-cycle bubble after reset, PC held at RESET_VECTOR, fetch invalid
// S_RUN   | normal fetch, PC advances or redirects every unstalled cycle
// S_FAULT | one-cycle bubble after a misaligned redirect, PC already at TRAP_VECTOR
module pc_gen #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'('h4),
  parameter int unsigned           INSTR_BYTES  = 4,
  parameter int unsigned           ALIGN_BITS   = 2
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam logic [DATA_WIDTH-1:0] STEP    = DATA_WIDTH'(INSTR_BYTES);
  localparam logic [DATA_WIDTH-1:0] JR_MASK = ~(DATA_WIDTH'(1));

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] epc_q;
  logic [DATA_WIDTH-1:0] fault_addr_q;
  logic                  pc_valid_q;
  logic                  misalign_q;

  logic [DATA_WIDTH-1:0] tgt_br;
  logic [DATA_WIDTH-1:0] tgt_jr;
  logic [DATA_WIDTH-1:0] tgt;
  logic [DATA_WIDTH-1:0] pc_seq;
  logic                  redirect;
  logic                  tgt_misaligned;

  always_comb begin
    tgt_br         = pc_q + bus.ImmOp;
    tgt_jr         = (bus.rs1_val + bus.ImmOp) & JR_MASK;
    pc_seq         = pc_q + STEP;
    redirect       = (bus.PCsrc == 2'b01) || (bus.PCsrc == 2'b10);
    tgt            = (bus.PCsrc == 2'b10) ? tgt_jr : tgt_br;
    tgt_misaligned = |tgt[ALIGN_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      fault_addr_q <= '0;
      pc_valid_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        S_BOOT, S_FAULT: begin
          state_q    <= S_RUN;
          pc_valid_q <= 1'b1;
        end
        S_RUN: begin
          pc_valid_q <= 1'b1;
          // trap_req outranks stall so a pending exception is never lost behind a hazard
          if (bus.trap_req) begin
            pc_q  <= TRAP_VECTOR;
            epc_q <= pc_q;
          end else if (bus.stall) begin
            pc_q <= pc_q;
          end else if (bus.trap_ret) begin
            pc_q <= epc_q;
          end else if (redirect && tgt_misaligned) begin
            pc_q         <= TRAP_VECTOR;
            epc_q        <= pc_q;
            fault_addr_q <= tgt;
            misalign_q   <= 1'b1;
            pc_valid_q   <= 1'b0;
            state_q      <= S_FAULT;
          end else if (redirect) begin
            pc_q <= tgt;
          end else begin
            pc_q <= pc_seq;
          end
        end
        default: begin
          state_q    <= S_BOOT;
          pc_q       <= RESET_VECTOR;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pcounter   = pc_q;
  assign bus.pc_plus    = pc_seq;
  assign bus.pc_valid   = pc_valid_q;
  assign bus.misalign   = misalign_q;
  assign bus.fault_addr = fault_addr_q;
  assign bus.epc        = epc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed stimulus pushes hand-computed expectations, a monitor
// pops and compares them one cycle later.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_gen_if #(.DATA_WIDTH(32)) bus ();

  pc_gen #(
    .DATA_WIDTH  (32),
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0004),
    .INSTR_BYTES (4),
    .ALIGN_BITS  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        mis;
    logic [31:0] fa;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, " pcounter"}, bus.pcounter, e.pc);
    check({tag, " pc_plus"}, bus.pc_plus, e.pc + 32'd4);
    check({tag, " pc_valid"}, {31'd0, bus.pc_valid}, {31'd0, e.v});
    check({tag, " misalign"}, {31'd0, bus.misalign}, {31'd0, e.mis});
    check({tag, " fault_addr"}, bus.fault_addr, e.fa);
    check({tag, " epc"}, bus.epc, e.epc);
  endtask

  // Called at a negedge: applies inputs for the next rising edge and queues the expected result.
  task automatic drive(input logic st, input logic [1:0] src, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic tq, input logic tr,
                       input logic [31:0] pc, input logic v, input logic mis,
                       input logic [31:0] fa, input logic [31:0] epc);
    exp_t e;
    bus.stall    = st;
    bus.PCsrc    = src;
    bus.ImmOp    = imm;
    bus.rs1_val  = rs1;
    bus.trap_req = tq;
    bus.trap_ret = tr;
    e.pc = pc; e.v = v; e.mis = mis; e.fa = fa; e.epc = epc;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_all("step", e);
      end
    end
  end

  initial begin : stim
    exp_t r;
    r.pc = 32'h0; r.v = 1'b0; r.mis = 1'b0; r.fa = 32'h0; r.epc = 32'h0;
    bus.stall = 1'b0; bus.PCsrc = 2'b00; bus.ImmOp = '0; bus.rs1_val = '0;
    bus.trap_req = 1'b0; bus.trap_ret = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_all("reset", r);
    rst = 1'b0;

    // boot bubble then sequential fetch
    drive(0, 2'b00, 32'h0,         32'h0, 0, 0, 32'h0000_0000, 1, 0, 32'h0, 32'h0);
    drive(0, 2'b00, 32'h0,         32'h0, 0, 0, 32'h0000_0004, 1, 0, 32'h0, 32'h0);
    drive(0, 2'b00, 32'h0,         32'h0, 0, 0, 32'h0000_0008, 1, 0, 32'h0, 32'h0);
    // PC-relative, negative offset, wrap
    drive(0, 2'b01, 32'h0000_00F8, 32'h0, 0, 0, 32'h0000_0100, 1, 0, 32'h0, 32'h0);
    drive(0, 2'b01, 32'hFFFF_FFF0, 32'h0, 0, 0, 32'h0000_00F0, 1, 0, 32'h0, 32'h0);
    drive(0, 2'b01, 32'hFFFF_FF0C, 32'h0, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'h0, 32'h0);
    drive(0, 2'b00, 32'h0,         32'h0, 0, 0, 32'h0000_0000, 1, 0, 32'h0, 32'h0);
    drive(0, 2'b00, 32'h0,         32'h0, 0, 0, 32'h0000_0004, 1, 0, 32'h0, 32'h0);
    drive(0, 2'b00, 32'h0,         32'h0, 0, 0, 32'h0000_0008, 1, 0, 32'h0, 32'h0);
    // misaligned JALR: fault, then FAULT bubble ignores a trap_req and a branch
    drive(0, 2'b10, 32'h0, 32'h0000_0203, 0, 0, 32'h0000_0004, 0, 1, 32'h202, 32'h8);
    drive(0, 2'b01, 32'h0000_0100, 32'h0, 1, 0, 32'h0000_0004, 1, 0, 32'h202, 32'h8);
    drive(0, 2'b00, 32'h0,         32'h0, 0, 0, 32'h0000_0008, 1, 0, 32'h202, 32'h8);
    // stall holds through branch/trap_ret; trap_req still taken under stall
    drive(0, 2'b01, 32'h0000_0038, 32'h0, 0, 0, 32'h0000_0040, 1, 0, 32'h202, 32'h8);
    for (int i = 0; i < 3; i++)
      drive(1, 2'b01, 32'h0000_0100, 32'h0, 0, 1, 32'h0000_0040, 1, 0, 32'h202, 32'h8);
    drive(1, 2'b00, 32'h0,         32'h0, 1, 0, 32'h0000_0004, 1, 0, 32'h202, 32'h40);
    drive(0, 2'b00, 32'h0,         32'h0, 0, 0, 32'h0000_0008, 1, 0, 32'h202, 32'h40);
    // trap_req beats trap_ret, later trap_ret returns to epc
    drive(0, 2'b01, 32'h0000_0078, 32'h0, 0, 0, 32'h0000_0080, 1, 0, 32'h202, 32'h40);
    drive(0, 2'b00, 32'h0,         32'h0, 1, 1, 32'h0000_0004, 1, 0, 32'h202, 32'h80);
    drive(0, 2'b00, 32'h0,         32'h0, 0, 0, 32'h0000_0008, 1, 0, 32'h202, 32'h80);
    drive(0, 2'b00, 32'h0,         32'h0, 0, 1, 32'h0000_0080, 1, 0, 32'h202, 32'h80);
    drive(0, 2'b00, 32'h0,         32'h0, 0, 0, 32'h0000_0084, 1, 0, 32'h202, 32'h80);
    // aligned JALR with bit0 cleared, reserved PCsrc is sequential, misaligned branch
    drive(0, 2'b10, 32'h0000_00FF, 32'h0000_1001, 0, 0, 32'h0000_1100, 1, 0, 32'h202, 32'h80);
    drive(0, 2'b11, 32'h0000_0040, 32'h0,         0, 0, 32'h0000_1104, 1, 0, 32'h202, 32'h80);
    drive(0, 2'b01, 32'h0000_0002, 32'h0,         0, 0, 32'h0000_0004, 0, 1, 32'h1106, 32'h1104);

    // asynchronous reset mid-FAULT, between clock edges
    bus.stall = 1'b0; bus.PCsrc = 2'b00; bus.ImmOp = '0; bus.trap_req = 1'b0; bus.trap_ret = 1'b0;
    #2 rst = 1'b1;
    #1 check_all("async_reset", r);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0000_0000, 1, 0, 32'h0, 32'h0);
    drive(0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0000_0004, 1, 0, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
